regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back controller for the 32x32 register file. It shares the file's single write port (RegWrite/rd/wd) between three requesters: ALU result, load data, and a debug/host port. It uses a valid/ready handshake with round-robin arbitration. After every reset it runs an init sequence that writes a known value into every register before normal write-back is allowed.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- NREG, 32, registers swept by init (must be ≤ 2^ADDR_W)
- INIT_VALUE, 32'h0, value written to every register during init
- INIT_EN, 1, 1 = run init sweep after reset; 0 = enter RUN directly
- clk  in  1  single clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- req_valid  in  3  per-requester write request; bit0 ALU, bit1 load, bit2 debug
- req_ready  out  3  per-requester grant; a transfer occurs when valid&ready in the same cycle
- req_rd  in  3*ADDR_W  destination register, requester i in bits [i*ADDR_W +: ADDR_W]
- req_data  in  3*DATA_W  write data, requester i in bits [i*DATA_W +: DATA_W]
- RegWrite  out  1  registered write enable to register file
- rd  out  ADDR_W  registered write address
- wd  out  DATA_W  registered write data
- grant_id  out  2  registered index of the requester whose write is on rd/wd (3 = init)
- init_done  out  1  high once the init sweep has finished, stays high until Reset

## Operation
- States: INIT and RUN. Reset forces INIT, or RUN if INIT_EN=0. The init counter and priority pointer are cleared.
- Reset values: RegWrite=0, rd=0, wd=0, grant_id=0, init_done=0 (1 if INIT_EN=0), req_ready=0, init counter=0, pointer=0.
- INIT:
  - Each cycle, register RegWrite=1, rd=counter, wd=INIT_VALUE, grant_id=3, then increment counter.
  - When the counter reaches NREG-1, that write is issued, init_done is set, and state goes to RUN.
  - req_ready=0 throughout INIT.
- RUN:
  - req_ready is combinational from req_valid, state and pointer.
  - At most one bit of req_ready is high per cycle, and only for a requester with valid=1.
  - Round-robin: the search starts at requester (pointer+1) mod 3 and wraps. The first valid requester is granted.
  - After a transfer, pointer = granted index. With no transfer, pointer holds.
  - After reset pointer=0, so the first search order is 1,2,0.
  - On a transfer, the next edge registers rd=req_rd[i], wd=req_data[i], grant_id=i, and RegWrite=1, except:
    - x0 suppression: if req_rd[i]==0, RegWrite=0 but the handshake still completes and the pointer still advances.
  - With no transfer, the next edge registers RegWrite=0; rd, wd and grant_id hold their previous values.
- Requesters must hold valid, rd and data stable until ready. The arbiter never withdraws ready from a valid requester within a cycle.
- Reset during INIT or RUN: the next edge returns to the reset values. A partially swept init restarts from register 0. A request presented in the Reset cycle is not accepted.

## Timing
- Write latency:
  - A request accepted at edge N (valid&ready sampled high) appears on RegWrite/rd/wd after edge N.
  - The register file commits it at edge N+1.
- Throughput is one write per cycle. A single requester holding valid continuously is granted every cycle.
- Init timeline, for Reset sampled high at edge k and low at edge k+1:
  - Edges k+1..k+NREG present rd=0..NREG-1.
  - init_done=1 after edge k+NREG.
  - req_ready can first be high in the cycle after edge k+NREG.
  - The first requester write appears after edge k+NREG+1.
- Contention: with all three valid continuously from RUN entry, grants rotate 1,2,0,1,2,0… Each requester waits at most 2 cycles.

## Test plan
- Init sweep, default params: pulse Reset for 2 cycles. Required: 32 consecutive cycles of RegWrite=1 with rd 0..31, wd=0, grant_id=3; init_done rises with the rd=31 cycle; req_ready=0 throughout.
- Single write: in RUN, ALU valid with rd=5, data=32'h0A. Required: req_ready[0]=1 the same cycle; next cycle RegWrite=1, rd=5, wd=32'h0A, grant_id=0; the cycle after, RegWrite=0.
- Three-way contention: from fresh RUN, all valid with rd=1,2,3 and data 32'h11,32'h22,32'h33, each dropping valid after its transfer. Required: RegWrite on three consecutive cycles in order grant_id 1,2,0 (rd 2,3,1).
- x0 suppression: load valid with rd=0, data=32'hFFFF_FFFF. Required: the handshake completes (ready[1]=1), RegWrite stays 0 next cycle, and the pointer has advanced (a following simultaneous ALU+debug request grants debug first).
- Sustained single requester: debug valid for 8 cycles, incrementing rd 8..15. Required: 8 consecutive RegWrite=1 with rd 8..15, no bubbles.
- Reset mid-init: assert Reset when rd=17 is on the port. Required: next cycle RegWrite=0, init_done=0; after release the sweep restarts at rd=0 and runs all 32 entries.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for a single-write-port register file: an init sweep after
// reset, then round-robin valid/ready arbitration among ALU, load and debug.
module regfile_wb_arbiter #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 5,
  parameter int unsigned       NREG       = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter bit                INIT_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  input  logic [3*ADDR_W-1:0]   req_rd,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic                  RegWrite,
  output logic [ADDR_W-1:0]     rd,
  output logic [DATA_W-1:0]     wd,
  output logic [1:0]            grant_id,
  output logic                  init_done
);

  localparam int unsigned       NREQ     = 3;
  localparam logic [0:0]        ST_INIT  = 1'b0;
  localparam logic [0:0]        ST_RUN   = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG - 1);
  localparam logic [1:0]        INIT_ID  = 2'd3;

  logic [0:0]        state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [1:0]        ptr, ptr_n;
  logic              we_n;
  logic [ADDR_W-1:0] rd_n;
  logic [DATA_W-1:0] wd_n;
  logic [1:0]        gid_n;
  logic              done_n;

  logic [1:0]        cand0, cand1, gidx;
  logic              xfer;

  logic [ADDR_W-1:0] rd_arr   [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign rd_arr[g]   = req_rd[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  function automatic logic [1:0] wrap_inc(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    cand0 = wrap_inc(ptr);
    cand1 = wrap_inc(cand0);
    xfer  = 1'b1;
    gidx  = ptr;
    if (req_valid[cand0])      gidx = cand0;
    else if (req_valid[cand1]) gidx = cand1;
    else if (req_valid[ptr])   gidx = ptr;
    else                       xfer = 1'b0;
    // Nothing is accepted outside RUN or while reset is being applied.
    if ((state != ST_RUN) || Reset) xfer = 1'b0;
  end

  assign req_ready = xfer ? (3'b001 << gidx) : 3'b000;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    we_n    = 1'b0;
    rd_n    = rd;
    wd_n    = wd;
    gid_n   = grant_id;
    done_n  = init_done;
    case (state)
      ST_INIT: begin
        we_n  = 1'b1;
        rd_n  = cnt;
        wd_n  = INIT_VALUE;
        gid_n = INIT_ID;
        cnt_n = cnt + ADDR_W'(1);
        if (cnt == LAST_REG) begin
          done_n  = 1'b1;
          state_n = ST_RUN;
        end
      end
      default: begin
        if (xfer) begin
          ptr_n = gidx;
          rd_n  = rd_arr[gidx];
          wd_n  = data_arr[gidx];
          gid_n = gidx;
          // x0 is hardwired zero: the handshake completes but nothing is written.
          we_n  = (rd_arr[gidx] != '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= INIT_EN ? ST_INIT : ST_RUN;
      cnt       <= '0;
      ptr       <= '0;
      RegWrite  <= 1'b0;
      rd        <= '0;
      wd        <= '0;
      grant_id  <= '0;
      init_done <= !INIT_EN;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ptr       <= ptr_n;
      RegWrite  <= we_n;
      rd        <= rd_n;
      wd        <= wd_n;
      grant_id  <= gid_n;
      init_done <= done_n;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a behavioural
// round-robin write-back model.
module tb_regfile_wb_arbiter;

  localparam int unsigned NREG = 32;
  localparam logic [31:0] INIT_VAL = 32'h0;

  logic        clk;
  logic        rst;
  logic [2:0]  valid;
  logic [2:0]  req_ready;
  logic [4:0]  rds [3];
  logic [31:0] dat [3];
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [1:0]  grant_id;
  logic        init_done;

  assign req_rd   = {rds[2], rds[1], rds[0]};
  assign req_data = {dat[2], dat[1], dat[0]};

  regfile_wb_arbiter dut (
    .clk       (clk),
    .Reset     (rst),
    .req_valid (valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .RegWrite  (RegWrite),
    .rd        (rd),
    .wd        (wd),
    .grant_id  (grant_id),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;

  // Behavioural model state
  bit          m_init;
  int          m_cnt;
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic [1:0]  m_gid;
  logic        m_done;
  logic [2:0]  last_ready;
  logic [2:0]  dut_ready_pre;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic cycle();
    logic [2:0] er;
    #1;
    er = 3'b000;
    if (!rst && !m_init) begin
      for (int k = 1; k <= 3; k++) begin
        int i;
        i = (m_ptr + k) % 3;
        if (valid[i] && er == 3'b000) er[i] = 1'b1;
      end
    end
    dut_ready_pre = req_ready;
    chk("ready", 32'(req_ready), 32'(er));
    last_ready = er;
    @(posedge clk);
    if (rst) begin
      m_init = 1'b1; m_cnt = 0; m_ptr = 0; m_we = 1'b0;
      m_rd = '0; m_wd = '0; m_gid = '0; m_done = 1'b0;
    end else if (m_init) begin
      m_we = 1'b1; m_rd = 5'(m_cnt); m_wd = INIT_VAL; m_gid = 2'd3;
      if (m_cnt == NREG - 1) begin
        m_done = 1'b1;
        m_init = 1'b0;
      end
      m_cnt++;
    end else begin
      m_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (er[i]) begin
          m_ptr = i; m_rd = rds[i]; m_wd = dat[i]; m_gid = 2'(i);
          m_we = (rds[i] != 5'd0);
        end
      end
    end
    #1;
    chk("regwrite",  32'(RegWrite),  32'(m_we));
    chk("rd",        32'(rd),        32'(m_rd));
    chk("wd",        wd,             m_wd);
    chk("grant_id",  32'(grant_id),  32'(m_gid));
    chk("init_done", 32'(init_done), 32'(m_done));
  endtask

  initial begin
    int   n;
    bit   found;
    logic [1:0] order [3];
    logic [4:0] ord_rd [3];

    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    valid    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      rds[i] = '0;
      dat[i] = '0;
    end

    // Reset pulse of two cycles, then the full init sweep
    cycle();
    cycle();
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_done",     32'(init_done), 32'd0);
    rst = 1'b0;
    for (int j = 0; j < 32; j++) begin
      cycle();
      chk("init_rd",    32'(rd), 32'(j));
      chk("init_we",    32'(RegWrite), 32'd1);
      chk("init_gid",   32'(grant_id), 32'd3);
      chk("init_wd",    wd, 32'h0);
      chk("init_rdy",   32'(dut_ready_pre), 32'd0);
      chk("init_done_edge", 32'(init_done), (j == 31) ? 32'd1 : 32'd0);
    end

    // Three-way contention from fresh RUN
    valid = 3'b111;
    rds[0] = 5'd1; rds[1] = 5'd2; rds[2] = 5'd3;
    dat[0] = 32'h11; dat[1] = 32'h22; dat[2] = 32'h33;
    order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd0;
    ord_rd[0] = 5'd2; ord_rd[1] = 5'd3; ord_rd[2] = 5'd1;
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk("cont_gid", 32'(grant_id), 32'(order[j]));
      chk("cont_rd",  32'(rd), 32'(ord_rd[j]));
      chk("cont_we",  32'(RegWrite), 32'd1);
      valid = valid & ~last_ready;
    end

    // Single ALU write
    valid = 3'b001; rds[0] = 5'd5; dat[0] = 32'h0A;
    cycle();
    chk("single_ready", 32'(dut_ready_pre), 32'b001);
    chk("single_we",    32'(RegWrite), 32'd1);
    chk("single_rd",    32'(rd), 32'd5);
    chk("single_wd",    wd, 32'h0A);
    chk("single_gid",   32'(grant_id), 32'd0);
    valid = 3'b000;
    cycle();
    chk("single_idle_we", 32'(RegWrite), 32'd0);

    // Debug write moves pointer to 2, then x0 load write must move it to 1
    valid = 3'b100; rds[2] = 5'd9; dat[2] = 32'h99;
    cycle();
    valid = 3'b010; rds[1] = 5'd0; dat[1] = 32'hFFFF_FFFF;
    cycle();
    chk("x0_ready", 32'(dut_ready_pre), 32'b010);
    chk("x0_we",    32'(RegWrite), 32'd0);
    valid = 3'b101; rds[0] = 5'd6; dat[0] = 32'h66; rds[2] = 5'd7; dat[2] = 32'h77;
    cycle();
    chk("x0_ptr_debug_first", 32'(dut_ready_pre), 32'b100);
    chk("x0_next_gid",        32'(grant_id), 32'd2);
    valid = 3'b000;
    cycle();

    // Sustained debug requester, no bubbles
    valid = 3'b100;
    for (int j = 0; j < 8; j++) begin
      rds[2] = 5'(8 + j);
      dat[2] = 32'h1000 + 32'(j);
      cycle();
      chk("sus_we", 32'(RegWrite), 32'd1);
      chk("sus_rd", 32'(rd), 32'(8 + j));
    end
    valid = 3'b000;
    cycle();

    // Reset mid-init at rd=17, sweep must restart from 0
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 40) begin
      cycle();
      if (RegWrite && rd == 5'd17) found = 1'b1;
      n++;
    end
    chk("wait_rd17", 32'(found), 32'd1);
    rst = 1'b1;
    cycle();
    chk("midrst_we",   32'(RegWrite), 32'd0);
    chk("midrst_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    for (int j = 0; j < 32; j++) begin
      cycle();
      chk("reinit_rd", 32'(rd), 32'(j));
      chk("reinit_we", 32'(RegWrite), 32'd1);
    end
    chk("reinit_done", 32'(init_done), 32'd1);

    // Randomized traffic obeying hold-until-ready, with occasional resets
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 119) == 0);
      cycle();
      for (int i = 0; i < 3; i++) begin
        if (!valid[i] || last_ready[i]) begin
          valid[i] = 1'($urandom_range(0, 1));
          rds[i]   = 5'($urandom);
          dat[i]   = $urandom;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
